layer_deserializer: RTL

// - Receive end of the inter-layer word stream: collects NUM serial DW-bit words (one per x_valid beat)
//   and presents them as one parallel NUM*DW vector for the next layer's per-neuron inputs.
// - Sits after a layer-output serializer, or on the host/test side to rebuild a layer result.
// - Double-buffered: the next frame is collected while the previous frame waits on out_ready.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/layer_deser_gap_timer.sv | 52 +++++
 rtl/layer_deserializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants for the neural-network layer datapath: fixed-point word
// width, per-layer neuron counts, and the state encoding used by the
// inter-layer word deserializer.
// No ports (package).
// -----------------------------------------------------------------------------
package nn_pkg;

  // Fixed-point neuron value width
  localparam int NN_DW = 16;

  // Neuron counts of the three layers
  localparam int NN_L0_SIZE = 30;
  localparam int NN_L1_SIZE = 30;
  localparam int NN_L2_SIZE = 10;

  // Deserializer state encoding
  typedef logic [1:0] deser_state_t;
  localparam logic [1:0] ST_IDLE    = 2'd0;  // no words collected
  localparam logic [1:0] ST_COLLECT = 2'd1;  // 1..NUM-1 words collected
  localparam logic [1:0] ST_FULL    = 2'd2;  // complete frame parked, output busy

endpackage

// File: rtl/layer_deser_gap_timer.sv
// -----------------------------------------------------------------------------
// layer_deser_gap_timer
// Counts idle cycles between accepted words of a partially collected frame.
// The count saturates at MAX_GAP; while it sits at MAX_GAP and counting is
// enabled, expire is asserted. MAX_GAP = 0 removes the timer entirely.
// Ports:
//   clk     in   clock
//   rst     in   synchronous, active-high reset
//   clear   in   restart the idle count (word accepted / frame dropped)
//   enable  in   count this cycle (deserializer is mid-frame)
//   expire  out  idle limit reached while enabled
// -----------------------------------------------------------------------------
module layer_deser_gap_timer #(
  parameter int MAX_GAP = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (MAX_GAP > 0) begin : g_timer
      localparam int TW = $clog2(MAX_GAP + 1);
      localparam logic [TW-1:0] LIMIT = TW'(MAX_GAP);
      localparam logic [TW-1:0] ONE   = TW'(1);

      logic [TW-1:0] gap_cnt_r;

      // Idle-cycle counter: cleared on request, saturates at the limit
      always_ff @(posedge clk) begin
        if (rst) begin
          gap_cnt_r <= {TW{1'b0}};
        end else if (clear) begin
          gap_cnt_r <= {TW{1'b0}};
        end else if (enable && (gap_cnt_r != LIMIT)) begin
          gap_cnt_r <= gap_cnt_r + ONE;
        end else begin
          gap_cnt_r <= gap_cnt_r;
        end
      end

      assign expire = enable && (gap_cnt_r == LIMIT);
    end else begin : g_no_timer
      logic unused_s;
      assign unused_s = ^{clk, rst, clear, enable};
      assign expire   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/layer_deserializer.sv
// -----------------------------------------------------------------------------
// layer_deserializer
// Receive side of the inter-layer word stream. Collects NUM serial DW-bit
// words (first accepted word lands in slot 0 / LSBs) and presents them as one
// parallel NUM*DW frame. Double-buffered: a new frame is collected while the
// previous one waits on out_ready; if a second frame completes while the
// output is still busy it is parked (FULL) and x_ready drops.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   x_in         serial word
//   x_valid      x_in valid; accepted when x_valid && x_ready
//   x_ready      decoded from the state register only
//   out_data     assembled frame, word k at [k*DW +: DW]
//   out_valid    out_data holds a complete frame
//   out_ready    consumer takes the frame when out_valid && out_ready
//   word_count   words in the current partial frame (NUM while parked)
//   frame_err    1-cycle pulse: partial frame dropped on idle timeout
//   overflow     1-cycle pulse: word offered while x_ready=0 and dropped
// -----------------------------------------------------------------------------
module layer_deserializer
  import nn_pkg::*;
#(
  parameter int DW      = NN_DW,
  parameter int NUM     = NN_L0_SIZE,
  parameter int MAX_GAP = 16,
  parameter int CW      = $clog2(NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [NUM*DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     word_count,
  output logic              frame_err,
  output logic              overflow
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM);

  deser_state_t      state_r, state_next_s;
  logic [CW-1:0]     count_r, count_next_s;
  logic [NUM*DW-1:0] buf_r, buf_next_s;
  logic [NUM*DW-1:0] out_data_r, out_data_next_s;
  logic              out_valid_r, out_valid_next_s;
  logic              frame_err_r, overflow_r;
  logic              x_ready_s, accept_s, expire_s, slot_free_s;
  logic              complete_s, transfer_s;
  logic [CW-1:0]     base_idx_s;

  // x_ready depends on the state register only
  always_comb begin
    case (state_r)
      ST_FULL: x_ready_s = 1'b0;
      default: x_ready_s = 1'b1;
    endcase
  end

  assign accept_s    = x_valid && x_ready_s;
  assign slot_free_s = !out_valid_r || out_ready;
  // On a timeout cycle the offered word restarts the frame at slot 0
  assign base_idx_s  = expire_s ? CNT_ZERO : count_r;
  assign complete_s  = accept_s && (base_idx_s == LAST_IDX);

  layer_deser_gap_timer #(
    .MAX_GAP (MAX_GAP)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept_s || expire_s),
    .enable (state_r == ST_COLLECT),
    .expire (expire_s)
  );

  // Collect buffer with this cycle's accepted word merged in
  always_comb begin
    buf_next_s = buf_r;
    if (accept_s) begin
      buf_next_s[int'(base_idx_s) * DW +: DW] = x_in;
    end else begin
      buf_next_s = buf_r;
    end
  end

  // Frame FSM, word counter and output-slot loading
  always_comb begin
    state_next_s    = state_r;
    count_next_s    = count_r;
    out_data_next_s = out_data_r;
    transfer_s      = 1'b0;
    if (accept_s) begin
      if (complete_s) begin
        if (slot_free_s) begin
          out_data_next_s = buf_next_s;
          transfer_s      = 1'b1;
          state_next_s    = ST_IDLE;
          count_next_s    = CNT_ZERO;
        end else begin
          state_next_s = ST_FULL;
          count_next_s = CNT_FULL;
        end
      end else begin
        state_next_s = ST_COLLECT;
        count_next_s = base_idx_s + CNT_ONE;
      end
    end else if (expire_s) begin
      state_next_s = ST_IDLE;
      count_next_s = CNT_ZERO;
    end else if ((state_r == ST_FULL) && out_ready) begin
      // Parked frame moves into the output slot as the old one is taken
      out_data_next_s = buf_r;
      transfer_s      = 1'b1;
      state_next_s    = ST_IDLE;
      count_next_s    = CNT_ZERO;
    end else begin
      state_next_s = state_r;
      count_next_s = count_r;
    end
  end

  // out_valid: a new frame wins over a same-cycle consume
  always_comb begin
    if (transfer_s) begin
      out_valid_next_s = 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_next_s = 1'b0;
    end else begin
      out_valid_next_s = out_valid_r;
    end
  end

  // State, buffers and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      count_r     <= CNT_ZERO;
      buf_r       <= {(NUM*DW){1'b0}};
      out_data_r  <= {(NUM*DW){1'b0}};
      out_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      buf_r       <= buf_next_s;
      out_data_r  <= out_data_next_s;
      out_valid_r <= out_valid_next_s;
      frame_err_r <= expire_s;
      overflow_r  <= x_valid && !x_ready_s;
    end
  end

  assign x_ready    = x_ready_s;
  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign word_count = count_r;
  assign frame_err  = frame_err_r;
  assign overflow   = overflow_r;

endmodule
